// File: rtl/fp16_fpu_arbiter.sv
// Round-robin arbiter sharing one FP16 FPU between NREQ requesters.
// An in-order tag FIFO routes each returned FPU result back to the requester that issued it.
module fp16_fpu_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DEPTH     = 16,
    parameter logic [7:0]  PIPE_MASK = 8'b0000_0011
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [3*NREQ-1:0]    req_opcode,
    input  logic [16*NREQ-1:0]   req_data1,
    input  logic [16*NREQ-1:0]   req_data2,
    input  logic [16*NREQ-1:0]   req_data3,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 drain,
    output logic                 drained,
    output logic [NREQ-1:0]      resp_valid,
    output logic [15:0]          resp_data,
    output logic [2:0]           resp_opcode,
    output logic                 err,
    output logic [15:0]          fpu_data1,
    output logic [15:0]          fpu_data2,
    output logic [15:0]          fpu_data3,
    output logic [2:0]           fpu_opcode,
    output logic                 fpu_input_valid,
    input  logic                 fpu_idle,
    input  logic                 fpu_output_up,
    input  logic [2:0]           fpu_opcode_o,
    input  logic [15:0]          fpu_data_o
);
    localparam int unsigned RrW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StRun, StDrain} state_e;
    state_e state_q, state_d;

    logic [RrW-1:0]  rr_ptr_q, gnt_idx, scan_idx, rr_next;
    logic            gnt_found;
    int unsigned     scan_sum;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic [2:0]      fifo_id [DEPTH];
    logic [2:0]      fifo_op [DEPTH];
    logic [2:0]      head_id, head_op;
    logic            fifo_empty, fifo_full, push, pop, can_issue;
    logic            err_q, drained_q;
    logic [NREQ-1:0] resp_valid_q;
    logic [15:0]     resp_data_q;
    logic [2:0]      resp_opcode_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (drain)  state_d = StDrain;
            StDrain: if (!drain) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // Rotating priority scan starting at rr_ptr_q.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        scan_sum  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_sum = 32'(rr_ptr_q) + k;
            if (scan_sum >= NREQ) scan_sum = scan_sum - NREQ;
            scan_idx = RrW'(scan_sum);
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(DEPTH));
    assign head_id    = fifo_id[rd_ptr_q];
    assign head_op    = fifo_op[rd_ptr_q];
    assign pop        = fpu_output_up & ~fifo_empty;
    assign rr_next    = (gnt_idx == RrW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    // Reset gates the accept pulse so req_ready is low while rst is asserted; the last term
    // blocks a second issue in the cycle before idle falls after an iterative op.
    assign can_issue = rst & (state_q == StRun) & fpu_idle & (~fifo_full | pop) &
                       ~(fpu_input_valid & ~PIPE_MASK[fpu_opcode]);
    assign push      = can_issue & gnt_found;
    assign req_ready = push ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr_q] <= 3'(gnt_idx);
            fifo_op[wr_ptr_q] <= req_opcode[3*int'(gnt_idx) +: 3];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StRun;
            rr_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            fpu_data1       <= '0;
            fpu_data2       <= '0;
            fpu_data3       <= '0;
            fpu_opcode      <= '0;
            fpu_input_valid <= 1'b0;
            resp_valid_q    <= '0;
            resp_data_q     <= '0;
            resp_opcode_q   <= '0;
            err_q           <= 1'b0;
            drained_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            fpu_input_valid <= push;
            if (push) begin
                rr_ptr_q   <= rr_next;
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                fpu_data1  <= req_data1[16*int'(gnt_idx) +: 16];
                fpu_data2  <= req_data2[16*int'(gnt_idx) +: 16];
                fpu_data3  <= req_data3[16*int'(gnt_idx) +: 16];
                fpu_opcode <= req_opcode[3*int'(gnt_idx) +: 3];
            end
            resp_valid_q <= pop ? (NREQ'(1) << head_id) : '0;
            if (pop) begin
                rd_ptr_q      <= rd_ptr_q + 1'b1;
                resp_data_q   <= fpu_data_o;
                resp_opcode_q <= fpu_opcode_o;
            end
            if ((fpu_output_up && fifo_empty) || (pop && (fpu_opcode_o != head_op))) begin
                err_q <= 1'b1;
            end
            // Registered, so drained rises the cycle after the last result is delivered.
            drained_q <= (state_q == StDrain) && fifo_empty;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_opcode = resp_opcode_q;
    assign err         = err_q;
    assign drained     = drained_q;
endmodule
